alu_seq_mc: RTL and testbench
=============================

Name: alu_seq_mc

Overview:
- Registered, parametrised ALU with a start/done handshake. Single-cycle ops: ADD, SUB, AND, OR, XOR, barrel pass-through. Multi-cycle shift-add MUL.
- Produces registered result plus zero, carry, negative and overflow flags.
- Sits in the datapath between the register-file read bus (RA_out), the write bus (BusW) and the barrel shifter output (saidaBarril). The control FSM drives Start/op and waits on Done.

Parameters:
WIDTH, 16, datapath width in bits for operands and result (legal range 4..32)

Ports:
Clock  input  1  single system clock, all state on rising edge
Resetn  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only while Busy=0
op  input  3  opcode, sampled with Start
RA_out  input  WIDTH  operand A
BusW  input  WIDTH  operand B
saidaBarril  input  WIDTH  barrel shifter result, passed through on op 100
Res  output  WIDTH  registered result
bitZero  output  1  registered, 1 when Res==0
Neg  output  1  registered, Res[WIDTH-1]
Carry  output  1  registered carry/borrow
Ovf  output  1  registered overflow
Busy  output  1  high while a MUL is in progress
Done  output  1  one-cycle pulse when Res/flags are updated

Behaviour:
- Reset (Resetn=0, async): Res=0, bitZero=1, Neg=0, Carry=0, Ovf=0, Busy=0, Done=0, FSM=IDLE, multiplier state cleared.
- FSM states: IDLE, MUL.
  - IDLE: Start=1 with a single-cycle op -> result registered at that edge, Done=1 next cycle, stay IDLE.
  - IDLE: Start=1 with op 111 -> capture RA_out/BusW, go to MUL.
  - MUL: exactly WIDTH iterations (one per cycle) -> register result, Done=1, back to IDLE.
- Latency:
  - Single-cycle op: Start in cycle n -> Done/Res valid in cycle n+1.
  - MUL: Start in cycle n -> Busy=1 in cycles n+1..n+WIDTH; Done=1, Busy=0 and Res valid in cycle n+WIDTH+1.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 000 NOP: Res and flags held; Done still pulses.
  - 001 ADD: Res=RA_out+BusW; Carry=carry-out; Ovf=signed overflow.
  - 010 SUB: Res=RA_out-BusW; Carry=borrow (1 when RA_out<BusW unsigned); Ovf=signed overflow.
  - 011 AND, 101 OR, 110 XOR: Carry=0, Ovf=0.
  - 100 PASS: Res=saidaBarril; Carry=0, Ovf=0.
  - 111 MUL: Res=low WIDTH bits of unsigned RA_out*BusW; Carry=0; Ovf=1 if upper WIDTH product bits are nonzero.
- Flags bitZero and Neg are always derived from the newly written Res, in the same edge.
- Start while Busy=1 is ignored (no queueing); op/operand changes during MUL have no effect.
- Start in the Done cycle of a previous op is accepted normally (back-to-back issue).
- Done is never high for more than one consecutive cycle per accepted Start.
- Resetn asserted mid-MUL: abort immediately, all outputs to reset values, no Done is generated.
- Outputs change only on a Done-producing edge or on reset; no latches, no combinational path from inputs to outputs.

Optional Feature:
Macro ALU_MUL_EN.
- Defined: MUL state and shift-add datapath present; op 111 behaves as above.
- Undefined: no multiplier logic, Busy tied 0. op 111 acts as NOP: Res/flags held, Done pulses in cycle n+1.

Test Plan:
- Reset: hold Resetn=0, then release -> Res=0x0000, bitZero=1, Neg=Carry=Ovf=Busy=Done=0.
- ADD overflow: RA_out=0x7FFF, BusW=0x0001, op=001, Start 1 cycle -> next cycle Res=0x8000, Neg=1, Ovf=1, Carry=0, bitZero=0, Done=1 for exactly one cycle.
- SUB borrow/zero:
  - RA_out=0x0003, BusW=0x0005, op=010 -> Res=0xFFFE, Carry=1, Ovf=0.
  - Back-to-back RA_out=BusW=0x1234 -> Res=0x0000, bitZero=1.
- PASS/logic: saidaBarril=0xA5A5, op=100 -> Res=0xA5A5; then RA_out=0xFF00, BusW=0x0FF0, op=110 -> Res=0xF0F0, Carry=Ovf=0.
- MUL (ALU_MUL_EN):
  - RA_out=0x0100, BusW=0x0300 -> Busy high 16 cycles; then Res=0x0000, Ovf=1, bitZero=1, Done one pulse.
  - Start pulses during Busy are ignored.
  - RA_out=0x0012, BusW=0x0034 -> Res=0x03A8, Ovf=0.
- Reset mid-MUL: assert Resetn=0 at Busy cycle 5 -> all outputs at reset values, no Done. After release, a new ADD 0x0001+0x0001 gives Res=0x0002.

Source files
------------

// File: rtl/alu_seq_mc.sv
// alu_seq_mc: registered ALU with a Start/Done handshake.
//   Single-cycle ops: NOP, ADD, SUB, AND, OR, XOR, PASS (barrel shifter result).
//   Multi-cycle op:   MUL (shift-add, WIDTH iterations), only when ALU_MUL_EN is defined;
//                     without ALU_MUL_EN, op 111 behaves as NOP and Busy is tied low.
// Ports:
//   Clock, Resetn            clock, asynchronous active-low reset
//   Start, op[2:0]           request and opcode, sampled while Busy=0
//   RA_out, BusW             operands A and B
//   saidaBarril              barrel shifter result for PASS
//   Res                      registered result
//   bitZero, Neg, Carry, Ovf registered flags
//   Busy                     high while a MUL is in progress
//   Done                     one-cycle pulse when Res/flags are updated
module alu_seq_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] RA_out,
  input  logic [WIDTH-1:0] BusW,
  input  logic [WIDTH-1:0] saidaBarril,
  output logic [WIDTH-1:0] Res,
  output logic             bitZero,
  output logic             Neg,
  output logic             Carry,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] res_n;
  logic             zero_n, neg_n, carry_n, ovf_n, done_n;
  logic [WIDTH:0]   add_sum, sub_diff;

`ifdef ALU_MUL_EN
  // prod holds {partial high word, remaining multiplier bits}; shifts right each step
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH:0]     step_sum;
  logic               busy_n;
`endif

  // Extra MSB captures carry-out (ADD) and borrow (SUB)
  assign add_sum  = {1'b0, RA_out} + {1'b0, BusW};
  assign sub_diff = {1'b0, RA_out} - {1'b0, BusW};

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    res_n   = Res;
    carry_n = Carry;
    ovf_n   = Ovf;
    done_n  = 1'b0;
`ifdef ALU_MUL_EN
    busy_n   = Busy;
    prod_n   = prod;
    mcand_n  = mcand;
    cnt_n    = cnt;
    step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
               (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`endif
    unique case (state)
      IDLE: begin
        if (Start) begin
          done_n = 1'b1;
          unique case (op)
            OP_ADD: begin
              res_n   = add_sum[WIDTH-1:0];
              carry_n = add_sum[WIDTH];
              ovf_n   = (RA_out[WIDTH-1] == BusW[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != RA_out[WIDTH-1]);
            end
            OP_SUB: begin
              res_n   = sub_diff[WIDTH-1:0];
              carry_n = sub_diff[WIDTH];
              ovf_n   = (RA_out[WIDTH-1] != BusW[WIDTH-1]) &&
                        (sub_diff[WIDTH-1] != RA_out[WIDTH-1]);
            end
            OP_AND:  begin res_n = RA_out & BusW; carry_n = 1'b0; ovf_n = 1'b0; end
            OP_OR:   begin res_n = RA_out | BusW; carry_n = 1'b0; ovf_n = 1'b0; end
            OP_XOR:  begin res_n = RA_out ^ BusW; carry_n = 1'b0; ovf_n = 1'b0; end
            OP_PASS: begin res_n = saidaBarril;   carry_n = 1'b0; ovf_n = 1'b0; end
            OP_MUL: begin
`ifdef ALU_MUL_EN
              done_n  = 1'b0;
              busy_n  = 1'b1;
              prod_n  = {{WIDTH{1'b0}}, BusW};
              mcand_n = RA_out;
              cnt_n   = '0;
              state_n = MUL;
`endif
            end
            OP_NOP:  ;
            default: ;
          endcase
        end
      end
      MUL: begin
`ifdef ALU_MUL_EN
        prod_n = {step_sum, prod[WIDTH-1:1]};
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          res_n   = prod_n[WIDTH-1:0];
          carry_n = 1'b0;
          ovf_n   = |prod_n[2*WIDTH-1:WIDTH];
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
    // Held results keep consistent flags since Res==0 <-> bitZero is invariant
    zero_n = (res_n == '0);
    neg_n  = res_n[WIDTH-1];
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      Res     <= '0;
      bitZero <= 1'b1;
      Neg     <= 1'b0;
      Carry   <= 1'b0;
      Ovf     <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_n;
      Res     <= res_n;
      bitZero <= zero_n;
      Neg     <= neg_n;
      Carry   <= carry_n;
      Ovf     <= ovf_n;
      Done    <= done_n;
    end
  end

`ifdef ALU_MUL_EN
  // Multiplier datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Busy  <= 1'b0;
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      Busy  <= busy_n;
      prod  <= prod_n;
      mcand <= mcand_n;
      cnt   <= cnt_n;
    end
  end
`else
  assign Busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_mc.sv
// Directed self-checking bench for alu_seq_mc (WIDTH=16); covers MUL when ALU_MUL_EN is defined.
module tb_alu_seq_mc;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] RA_out = '0, BusW = '0, saidaBarril = '0;
  logic [15:0] Res;
  logic        bitZero, Neg, Carry, Ovf, Busy, Done;

  int errors = 0;
  int checks = 0;

  // {Res, bitZero, Neg, Carry, Ovf, Done}
  logic [20:0] obs, exp_v;

  alu_seq_mc #(.WIDTH(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .op(op),
    .RA_out(RA_out), .BusW(BusW), .saidaBarril(saidaBarril),
    .Res(Res), .bitZero(bitZero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] p);
    Start = 1'b1; op = o; RA_out = a; BusW = b; saidaBarril = p;
  endtask

  task automatic idle();
    Start = 1'b0;
  endtask

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10000};
    checks++;
    if (obs !== exp_v || Busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %h busy=%b, want %h busy=0", obs, Busy, exp_v);
    end
    @(negedge Clock); Resetn = 1'b1;
    step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done};
    checks++;
    if (obs !== exp_v || Busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got %h busy=%b, want %h busy=0", obs, Busy, exp_v);
    end
  endtask

  task automatic test_add();
    drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h8000, 5'b01011};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_ovf: got %h, want %h", obs, exp_v); end
    step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h8000, 5'b01010};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_done_once: got %h, want %h", obs, exp_v); end
    drive(3'b001, 16'hFFFF, 16'h0001, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10101};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_carry: got %h, want %h", obs, exp_v); end
  endtask

  task automatic test_sub();
    drive(3'b010, 16'h0003, 16'h0005, 16'h0000); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'hFFFE, 5'b01101};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_borrow: got %h, want %h", obs, exp_v); end
    drive(3'b010, 16'h1234, 16'h1234, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_zero_b2b: got %h, want %h", obs, exp_v); end
    step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10000};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_done_once: got %h, want %h", obs, exp_v); end
    drive(3'b010, 16'h8000, 16'h0001, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h7FFF, 5'b00011};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_ovf: got %h, want %h", obs, exp_v); end
  endtask

  task automatic test_logic();
    drive(3'b100, 16'h1111, 16'h2222, 16'hA5A5); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'hA5A5, 5'b01001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pass: got %h, want %h", obs, exp_v); end
    drive(3'b110, 16'hFF00, 16'h0FF0, 16'h0000); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'hF0F0, 5'b01001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL xor: got %h, want %h", obs, exp_v); end
    drive(3'b011, 16'hFF00, 16'h0FF0, 16'h0000); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0F00, 5'b00001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL and: got %h, want %h", obs, exp_v); end
    drive(3'b101, 16'hFF00, 16'h0FF0, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'hFFF0, 5'b01001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL or: got %h, want %h", obs, exp_v); end
  endtask

  task automatic test_nop();
    drive(3'b001, 16'hFFFF, 16'h0001, 16'h0000); step();
    drive(3'b000, 16'h0005, 16'h0006, 16'h7777); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10101};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nop_hold: got %h, want %h", obs, exp_v); end
`ifndef ALU_MUL_EN
    drive(3'b111, 16'h0003, 16'h0003, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10101};
    checks++;
    if (obs !== exp_v || Busy !== 1'b0) begin
      errors++; $display("FAIL mul_as_nop: got %h busy=%b, want %h busy=0", obs, Busy, exp_v);
    end
`endif
    idle(); step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10100};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nop_done_once: got %h, want %h", obs, exp_v); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int busy_cycles;
    bit ended;
    drive(3'b111, 16'h0100, 16'h0300, 16'h0000); step(); idle();
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL mul_start: got busy=%b done=%b, want busy=1 done=0", Busy, Done);
    end
    busy_cycles = (Busy === 1'b1) ? 1 : 0;
    ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      // stray requests while busy must be ignored
      if (i % 3 == 0) drive(3'b001, 16'h0001, 16'h0001, 16'h0000);
      step(); idle();
      if (Busy !== 1'b1) begin ended = 1'b1; break; end
      busy_cycles++;
    end
    checks++;
    if (!ended || busy_cycles != 16) begin
      errors++; $display("FAIL mul_busy_len: got %0d cycles ended=%0d, want 16 cycles", busy_cycles, ended);
    end
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10011};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mul_ovf: got %h, want %h", obs, exp_v); end
    step();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10010};
    checks++;
    if (obs !== exp_v || Busy !== 1'b0) begin
      errors++; $display("FAIL mul_ignored_start: got %h busy=%b, want %h busy=0", obs, Busy, exp_v);
    end
    drive(3'b111, 16'h0012, 16'h0034, 16'h0000); step(); idle();
    ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Done === 1'b1) begin ended = 1'b1; break; end
      step();
    end
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h03A8, 5'b00001};
    checks++;
    if (!ended || obs !== exp_v) begin
      errors++; $display("FAIL mul_small: got %h ended=%0d, want %h", obs, ended, exp_v);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int done_seen;
`ifdef ALU_MUL_EN
    drive(3'b111, 16'h0100, 16'h0300, 16'h0000); step(); idle();
    repeat (4) step();
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy5: got busy=%b, want 1", Busy); end
`else
    drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000); step(); idle();
    step();
`endif
    #3 Resetn = 1'b0; #1;
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0000, 5'b10000};
    checks++;
    if (obs !== exp_v || Busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got %h busy=%b, want %h busy=0", obs, Busy, exp_v);
    end
    repeat (2) step();
    Resetn = 1'b1;
    done_seen = 0;
    repeat (20) begin
      step();
      if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL rst_mid_no_done: got %0d cycles with done/busy, want 0", done_seen);
    end
    drive(3'b001, 16'h0001, 16'h0001, 16'h0000); step(); idle();
    obs = {Res, bitZero, Neg, Carry, Ovf, Done}; exp_v = {16'h0002, 5'b00001};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_add: got %h, want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_nop();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
